// File: rtl/xy_zone_tracker_pkg.sv
// Shared definitions for the x/y zone tracker: region encoding, LED bit map and LED decode.
// Reused by the VGA overlay and the testbench.
package xy_zone_tracker_pkg;

    localparam logic [1:0] REG_LOW  = 2'd0;
    localparam logic [1:0] REG_MID  = 2'd1;
    localparam logic [1:0] REG_HIGH = 2'd2;

    localparam int unsigned NUM_LEDS   = 5;
    localparam int unsigned LED_RIGHT  = 0;
    localparam int unsigned LED_DOWN   = 1;
    localparam int unsigned LED_LEFT   = 2;
    localparam int unsigned LED_UP     = 3;
    localparam int unsigned LED_CENTRE = 4;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
    } zone_pair_t;

    // LED pattern for a committed zone pair; all dark while the track is lost.
    function automatic logic [NUM_LEDS-1:0] leds_for(zone_pair_t z, logic lost);
        logic [NUM_LEDS-1:0] l;
        l = '0;
        if (!lost) begin
            l[LED_RIGHT]  = (z.x == REG_HIGH);
            l[LED_LEFT]   = (z.x == REG_LOW);
            l[LED_UP]     = (z.y == REG_HIGH);
            l[LED_DOWN]   = (z.y == REG_LOW);
            l[LED_CENTRE] = (z.x == REG_MID) && (z.y == REG_MID);
        end
        return l;
    endfunction

endpackage

// File: rtl/xy_zone_tracker_axis.sv
// Single-axis LOW/MID/HIGH classifier with hysteresis around both thresholds.
// Purely combinational; the caller feeds back its committed region.
module axis_hyst_classifier
    import xy_zone_tracker_pkg::*;
#(
    parameter int unsigned W      = 11,
    parameter int unsigned MID    = 500,
    parameter int unsigned CENT_D = 250,
    parameter int unsigned HYST   = 16
) (
    input  logic [W-1:0] value,
    input  logic [1:0]   region,
    output logic [1:0]   cand_c
);

    localparam longint unsigned VAL_LIMIT = 64'(1) << W;
    localparam longint unsigned HI_TOP    = 64'(MID) + 64'(CENT_D) + 64'(HYST);

    if ((CENT_D + HYST > MID) || (HI_TOP >= VAL_LIMIT) || (HYST >= CENT_D)) begin : g_bad_params
        $error("axis_hyst_classifier: thresholds do not fit the coordinate range");
    end

    localparam logic [W-1:0] HI_ENTER = W'(MID + CENT_D + HYST);
    localparam logic [W-1:0] HI_EXIT  = W'(MID + CENT_D - HYST);
    localparam logic [W-1:0] LO_ENTER = W'(MID - CENT_D - HYST);
    localparam logic [W-1:0] LO_EXIT  = W'(MID - CENT_D + HYST);

    // Leaving a region needs crossing its threshold by HYST the other way; an unknown region acts as MID.
    always_comb begin
        cand_c = REG_MID;
        case (region)
            REG_HIGH: begin
                if (value < LO_ENTER)     cand_c = REG_LOW;
                else if (value < HI_EXIT) cand_c = REG_MID;
                else                      cand_c = REG_HIGH;
            end
            REG_LOW: begin
                if (value > HI_ENTER)     cand_c = REG_HIGH;
                else if (value > LO_EXIT) cand_c = REG_MID;
                else                      cand_c = REG_LOW;
            end
            default: begin
                if (value > HI_ENTER)      cand_c = REG_HIGH;
                else if (value < LO_ENTER) cand_c = REG_LOW;
                else                       cand_c = REG_MID;
            end
        endcase
    end

endmodule

// File: rtl/xy_zone_tracker.sv
// Registered x/y zone tracker: hysteretic per-axis classification, N-sample debounce,
// loss-of-track timeout and status LED drive.
module xy_zone_tracker
    import xy_zone_tracker_pkg::*;
#(
    parameter int unsigned W       = 11,
    parameter int unsigned MID_X   = 500,
    parameter int unsigned MID_Y   = 500,
    parameter int unsigned CENT_D  = 250,
    parameter int unsigned HYST    = 16,
    parameter int unsigned STABLE  = 3,
    parameter int unsigned TIMEOUT = 100
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         valid,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [4:0]   leds,
    output logic [1:0]   zone_x,
    output logic [1:0]   zone_y,
    output logic         lost
);

    if ((STABLE == 0) || (TIMEOUT == 0)) begin : g_bad_params
        $error("xy_zone_tracker: STABLE and TIMEOUT must be at least 1");
    end

    localparam int unsigned CW = $clog2(STABLE + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam zone_pair_t CENTRE = '{x: REG_MID, y: REG_MID};

    zone_pair_t    zone_q, zone_n;
    zone_pair_t    cand_q, cand_n;
    zone_pair_t    cand_c;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [TW-1:0] tcnt_q, tcnt_n;
    logic          lost_q, lost_n;
    logic [4:0]    leds_q, leds_n;

    axis_hyst_classifier #(.W(W), .MID(MID_X), .CENT_D(CENT_D), .HYST(HYST)) u_axis_x (
        .value  (x),
        .region (zone_q.x),
        .cand_c (cand_c.x)
    );

    axis_hyst_classifier #(.W(W), .MID(MID_Y), .CENT_D(CENT_D), .HYST(HYST)) u_axis_y (
        .value  (y),
        .region (zone_q.y),
        .cand_c (cand_c.y)
    );

    // Debounce and timeout next-state; a valid sample always beats an expiring timeout.
    always_comb begin
        zone_n = zone_q;
        cand_n = cand_q;
        cnt_n  = cnt_q;
        tcnt_n = tcnt_q;
        lost_n = lost_q;
        leds_n = leds_q;
        if (valid) begin
            tcnt_n = '0;
            if (cand_c == cand_q) begin
                if (cnt_q != CW'(STABLE)) cnt_n = cnt_q + CW'(1);
            end else begin
                cand_n = cand_c;
                cnt_n  = CW'(1);
            end
            if (cnt_n == CW'(STABLE)) begin
                zone_n = cand_c;
                lost_n = 1'b0;
            end
        end else if (tcnt_q != TW'(TIMEOUT)) begin
            tcnt_n = tcnt_q + TW'(1);
            if (tcnt_n == TW'(TIMEOUT)) begin
                lost_n = 1'b1;
                zone_n = CENTRE;
                cnt_n  = '0;
            end
        end
        leds_n = leds_for(zone_n, lost_n);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zone_q <= CENTRE;
            cand_q <= CENTRE;
            cnt_q  <= '0;
            tcnt_q <= '0;
            lost_q <= 1'b1;
            leds_q <= '0;
        end else begin
            zone_q <= zone_n;
            cand_q <= cand_n;
            cnt_q  <= cnt_n;
            tcnt_q <= tcnt_n;
            lost_q <= lost_n;
            leds_q <= leds_n;
        end
    end

    assign leds   = leds_q;
    assign zone_x = zone_q.x;
    assign zone_y = zone_q.y;
    assign lost   = lost_q;

endmodule

// File: tb/tb_xy_zone_tracker.sv
// Scoreboard bench for xy_zone_tracker: directed stimulus queues hand-computed expected
// outputs; an independent monitor pops and compares one entry after each clock edge.
module tb_xy_zone_tracker;
    import xy_zone_tracker_pkg::*;

    localparam int unsigned W = 11;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         valid;
    logic [W-1:0] x, y;
    logic [4:0]   leds;
    logic [1:0]   zone_x, zone_y;
    logic         lost;

    xy_zone_tracker dut (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   (valid),
        .x       (x),
        .y       (y),
        .leds    (leds),
        .zone_x  (zone_x),
        .zone_y  (zone_y),
        .lost    (lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] leds;
        logic       lost;
        logic [1:0] zx;
        logic [1:0] zy;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic compare(input string tag, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got leds=%b lost=%b zx=%0d zy=%0d, expected leds=%b lost=%b zx=%0d zy=%0d",
                     tag, $time, act[9:5], act[4], act[3:2], act[1:0], exp[9:5], exp[4], exp[3:2], exp[1:0]);
        end
    endtask

    task automatic set_exp(input logic [4:0] l, input logic lo, input logic [1:0] zx,
                           input logic [1:0] zy, input string tag);
        cur.leds = l; cur.lost = lo; cur.zx = zx; cur.zy = zy; cur.tag = tag;
    endtask

    task automatic drive(input logic v, input int xi, input int yi);
        @(negedge clk);
        valid = v;
        x = W'(xi);
        y = W'(yi);
        sb.push_back(cur);
    endtask

    task automatic samples(input int xi, input int yi, input int n);
        repeat (n) drive(1'b1, xi, yi);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0);
    endtask

    task automatic check_now(input string tag, input logic [4:0] l, input logic lo,
                             input logic [1:0] zx, input logic [1:0] zy);
        compare(tag, {leds, lost, zone_x, zone_y}, {l, lo, zx, zy});
    endtask

    // Monitor: one expected entry per sampled clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compare(e.tag, {leds, lost, zone_x, zone_y}, {e.leds, e.lost, e.zx, e.zy});
            end
        end
    end

    initial begin
        reset_n = 1'b1;
        valid   = 1'b1;
        x       = W'($urandom_range(0, 2047));
        y       = W'($urandom_range(0, 2047));

        // Asynchronous reset: outputs must settle before the next rising edge at t=15.
        #7 reset_n = 1'b0;
        #2 check_now("async_reset", 5'b00000, 1'b1, REG_MID, REG_MID);
        repeat (2) begin
            @(negedge clk);
            valid = 1'($urandom_range(0, 1));
            x = W'($urandom_range(0, 2047));
            y = W'($urandom_range(0, 2047));
        end
        @(posedge clk);
        #1 check_now("reset_hold", 5'b00000, 1'b1, REG_MID, REG_MID);
        @(negedge clk);
        valid   = 1'b0;
        reset_n = 1'b1;

        set_exp(5'b00000, 1'b1, REG_MID, REG_MID, "acquire_pending");
        samples(500, 500, 2);
        set_exp(5'b10000, 1'b0, REG_MID, REG_MID, "acquire_centre");
        samples(500, 500, 1);

        set_exp(5'b10000, 1'b0, REG_MID, REG_MID, "x760_inside_hyst");
        samples(760, 500, 3);
        set_exp(5'b10000, 1'b0, REG_MID, REG_MID, "x770_debouncing");
        samples(770, 500, 2);
        set_exp(5'b00001, 1'b0, REG_HIGH, REG_MID, "x770_high");
        samples(770, 500, 1);
        set_exp(5'b00001, 1'b0, REG_HIGH, REG_MID, "x740_holds_high");
        samples(740, 500, 3);
        samples(730, 500, 2);
        set_exp(5'b10000, 1'b0, REG_MID, REG_MID, "x730_back_mid");
        samples(730, 500, 1);

        set_exp(5'b10000, 1'b0, REG_MID, REG_MID, "debounce_reject");
        for (int i = 0; i < 20; i++) samples((i % 2 == 0) ? 770 : 500, 500, 1);

        samples(800, 200, 2);
        set_exp(5'b00011, 1'b0, REG_HIGH, REG_LOW, "corner_hi_lo");
        samples(800, 200, 1);
        set_exp(5'b00011, 1'b0, REG_HIGH, REG_LOW, "idle_before_timeout");
        idle(99);
        set_exp(5'b00000, 1'b1, REG_MID, REG_MID, "timeout_lost");
        idle(1);
        set_exp(5'b00000, 1'b1, REG_MID, REG_MID, "lost_stays");
        idle(3);

        set_exp(5'b00000, 1'b1, REG_MID, REG_MID, "reacquire_pending");
        samples(800, 200, 2);
        set_exp(5'b00011, 1'b0, REG_HIGH, REG_LOW, "reacquire_corner");
        samples(800, 200, 1);
        set_exp(5'b00011, 1'b0, REG_HIGH, REG_LOW, "valid_on_idle99");
        idle(98);
        samples(800, 200, 1);
        set_exp(5'b00011, 1'b0, REG_HIGH, REG_LOW, "no_timeout_after_refresh");
        idle(99);

        set_exp(5'b00011, 1'b0, REG_HIGH, REG_LOW, "pre_reset_debounce");
        samples(800, 800, 2);
        @(negedge clk);
        valid   = 1'b0;
        reset_n = 1'b0;
        #1 check_now("mid_op_reset", 5'b00000, 1'b1, REG_MID, REG_MID);
        @(negedge clk);
        reset_n = 1'b1;

        set_exp(5'b00000, 1'b1, REG_MID, REG_MID, "post_reset_run");
        samples(800, 800, 2);
        set_exp(5'b01001, 1'b0, REG_HIGH, REG_HIGH, "post_reset_commit");
        samples(800, 800, 1);
        set_exp(5'b01001, 1'b0, REG_HIGH, REG_HIGH, "post_reset_idle");
        idle(2);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
